// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receive path: FSM encoding,
// frame geometry and default timing parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int DATA_BITS      = 8;
  localparam int DEF_TICK_DIV   = 326;
  localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks, held in
// phase 0 while clear is high so ticks align to the event that released it.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, stop-bit check
// and a valid/ack holding register that flags framing and overrun events.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OVS_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [OVS_W-1:0] OVS_MID = OVS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OVS_W-1:0] OVS_END = OVS_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rxd_m;
  logic                 rxd_s;
  logic                 tick;
  logic [OVS_W-1:0]     ovs_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  // Line synchronizer; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RxD;
      rxd_s <= rxd_m;
    end
  end

  uart_rx_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ovs_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A commit in STOP below overrides this clear when both land together.
      if (data_ack) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          ovs_cnt <= '0;
          bit_idx <= '0;
          if (!rxd_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (ovs_cnt == OVS_MID) begin
              ovs_cnt <= '0;
              if (rxd_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (ovs_cnt == OVS_END) begin
              ovs_cnt <= '0;
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              if (bit_idx == IDX_END) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (ovs_cnt == OVS_END) begin
              ovs_cnt <= '0;
              if (rxd_s) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (!data_valid || data_ack) begin
                  data       <= shreg;
                  data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                state     <= WAIT_IDLE;
                frame_err <= 1'b1;
              end
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        WAIT_IDLE: begin
          // Break condition: hold off until the line returns to idle.
          if (rxd_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level driver plus an event model that
// predicts data/valid/error outputs from frame start times and ack activity.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int OVS      = 16;
  localparam int BIT      = TICK_DIV * OVS;
  localparam int LAT      = 611;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RxD = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .TICK_DIV  (TICK_DIV),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .data_ack  (data_ack),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    int         t;
    logic [7:0] b;
    bit         good;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ev_t  model_q[$];
  int   win_q[$];
  ev_t  m_ev;
  logic [7:0] m_data = 8'h00;
  bit   m_dv = 1'b0;
  bit   res_fe, res_ov, in_win, prev_dv;
  int   fe_cnt = 0, ov_cnt = 0, fe_total = 0, ov_total = 0;
  int   rise_cyc = 0, t0 = 0, fe_base, ov_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Model advances on the clock edge, then outputs are compared 1 time unit later.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_data = 8'h00;
      m_dv   = 1'b0;
      model_q.delete();
      win_q.delete();
      fe_cnt = 0;
      ov_cnt = 0;
    end else if (model_q.size() > 0 && model_q[0].t == cyc) begin
      m_ev   = model_q.pop_front();
      res_fe = !m_ev.good;
      res_ov = m_ev.good && m_dv && !data_ack;
      if (m_ev.good && (!m_dv || data_ack)) begin
        m_data = m_ev.b;
        m_dv   = 1'b1;
      end
    end else if (data_ack) begin
      m_dv = 1'b0;
    end
    #1;
    if (!reset) begin
      chk("rst data", data, 8'h00);
      chk("rst data_valid", data_valid, 1'b0);
      chk("rst frame_err", frame_err, 1'b0);
      chk("rst overrun", overrun, 1'b0);
      chk("rst busy", busy, 1'b0);
    end else begin
      fe_total += frame_err;
      ov_total += overrun;
      in_win = (win_q.size() > 0) && (cyc >= win_q[0] - 1);
      if (in_win) begin
        fe_cnt += frame_err;
        ov_cnt += overrun;
        if (cyc == win_q[0] + 1) begin
          chk("frame_err pulses", fe_cnt, res_fe);
          chk("overrun pulses", ov_cnt, res_ov);
          chk("data after commit", data, m_data);
          chk("data_valid after commit", data_valid, m_dv);
          fe_cnt = 0;
          ov_cnt = 0;
          void'(win_q.pop_front());
        end
      end else begin
        chk("frame_err idle", frame_err, 1'b0);
        chk("overrun idle", overrun, 1'b0);
        chk("data", data, m_data);
        chk("data_valid", data_valid, m_dv);
      end
    end
    if (data_valid && !prev_dv) rise_cyc = cyc;
    prev_dv = data_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, input int stop_len,
                            output int start_cyc);
    ev_t e;
    start_cyc = cyc;
    e.t    = cyc + LAT;
    e.b    = b;
    e.good = stopb;
    model_q.push_back(e);
    win_q.push_back(e.t);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i], BIT);
      if (i == 3) chk("busy in frame", busy, 1'b1);
    end
    drive_bit(stopb, stop_len);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    reset = 1'b1;
    idle(20);

    // 1: single frame 0x4D
    send_frame(8'h4D, 1'b1, BIT, t0);
    idle(10);
    chk("t1 data", data, 8'h4D);
    chk("t1 valid", data_valid, 1'b1);
    chk("t1 latency", (rise_cyc - t0 >= LAT - 1) && (rise_cyc - t0 <= LAT + 1), 1'b1);
    chk("t1 busy idle", busy, 1'b0);
    ack_pulse();
    idle(2);
    chk("t1 ack clears", data_valid, 1'b0);

    // 2: back-to-back without ack -> overrun on second byte
    ov_base = ov_total;
    send_frame(8'h4D, 1'b1, BIT, t0);
    send_frame(8'hF0, 1'b1, BIT, t0);
    idle(10);
    chk("t2 overrun count", ov_total - ov_base, 1);
    chk("t2 data kept", data, 8'h4D);
    chk("t2 valid", data_valid, 1'b1);
    ack_pulse();
    idle(2);
    chk("t2 ack clears", data_valid, 1'b0);

    // 3: ack in the commit cycle of the second byte
    ov_base = ov_total;
    send_frame(8'h4D, 1'b1, BIT, t0);
    fork
      send_frame(8'hF0, 1'b1, BIT, t0);
      begin
        repeat (LAT - 1) @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
      end
    join
    idle(10);
    chk("t3 data", data, 8'hF0);
    chk("t3 valid", data_valid, 1'b1);
    chk("t3 no overrun", ov_total - ov_base, 0);
    ack_pulse();
    idle(2);
    chk("t3 ack clears", data_valid, 1'b0);

    // 4: 16-clock glitch
    drive_bit(1'b0, 10);
    chk("t4 busy on glitch", busy, 1'b1);
    drive_bit(1'b0, 6);
    drive_bit(1'b1, 32);
    chk("t4 busy released", busy, 1'b0);
    chk("t4 no valid", data_valid, 1'b0);

    // 5: framing error with a 200-clock break, then a good byte
    fe_base = fe_total;
    send_frame(8'hAA, 1'b0, 200, t0);
    chk("t5 frame_err count", fe_total - fe_base, 1);
    chk("t5 busy in break", busy, 1'b1);
    chk("t5 no valid", data_valid, 1'b0);
    drive_bit(1'b1, 5);
    chk("t5 busy after break", busy, 1'b0);
    send_frame(8'h55, 1'b1, BIT, t0);
    idle(10);
    chk("t5 data 55", data, 8'h55);
    chk("t5 valid 55", data_valid, 1'b1);

    // 6: reset during data bit 4 of 0x4D, then a clean 0xF0
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(logic'((8'h4D >> i) & 1), BIT);
    drive_bit(1'b0, 30);
    chk("t6 busy before reset", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("t6 rst data", data, 8'h00);
    chk("t6 rst valid", data_valid, 1'b0);
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst frame_err", frame_err, 1'b0);
    RxD = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(10);
    fe_base = fe_total;
    ov_base = ov_total;
    send_frame(8'hF0, 1'b1, BIT, t0);
    idle(10);
    chk("t6 data", data, 8'hF0);
    chk("t6 valid", data_valid, 1'b1);
    chk("t6 no errors", (fe_total - fe_base) + (ov_total - ov_base), 0);
    chk("t6 busy idle", busy, 1'b0);

    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
